// File: rtl/calc_pkg.sv
// calc_pkg: key codes, ALU op codes and FSM states shared by the calculator sequencer.
package calc_pkg;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hD;
  localparam logic [3:0] KEY_BS  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, SHOW, ERROR} state_t;
  function automatic logic is_op(input logic [3:0] k);
    return k == KEY_ADD || k == KEY_SUB || k == KEY_MUL;
  endfunction
  function automatic logic [3:0] key_to_op(input logic [3:0] k);
    return k == KEY_ADD ? OP_ADD : k == KEY_SUB ? OP_SUB : OP_MUL;
  endfunction
endpackage

// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg: BCD operand shift register tracking its count of significant digits.
module bcd_entry_reg #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_clr,
  input  logic                  i_shift,
  input  logic                  i_back,
  input  logic                  i_load,
  input  logic [3:0]            i_digit,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_val
);
  localparam int CW = $clog2(DIGITS + 1);
  logic [4*DIGITS-1:0] r_val;
  logic [CW-1:0] r_cnt, w_sig;
  // a loaded value gets the count of its significant digits so later edits stay consistent
  always_comb begin
    w_sig = '0;
    for (int i = 0; i < DIGITS; i++) w_sig = i_load_val[4*i+:4] != 4'd0 ? CW'(i + 1) : w_sig;
  end
  always_ff @(posedge clk) begin
    if (!resetn || i_clr) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_val <= i_load_val;
      r_cnt <= w_sig;
    end else if (i_shift && r_cnt != CW'(DIGITS)) begin
      r_val <= {r_val[4*DIGITS-5:0], i_digit};
      r_cnt <= (r_cnt == '0 && i_digit == 4'd0) ? '0 : r_cnt + 1'b1;
    end else if (i_back) begin
      r_val <= {4'd0, r_val[4*DIGITS-1:4]};
      r_cnt <= r_cnt == '0 ? '0 : r_cnt - 1'b1;
    end
  end
  assign o_val = r_val;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven BCD calculator sequencer handing operations to an external ALU.
// Define CALC_CHAIN_EN to let an operator in SHOW chain the result into operand A.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_key_valid,
  input  logic [3:0]          i_key_code,
  output logic [4*DIGITS-1:0] o_alu_num1,
  output logic [4*DIGITS-1:0] o_alu_num2,
  output logic [3:0]          o_alu_op,
  output logic                o_alu_req,
  input  logic                i_alu_ack,
  input  logic [4*DIGITS-1:0] i_alu_res,
  input  logic                i_alu_err,
  output logic [4*DIGITS-1:0] o_display,
  output logic                o_disp_err,
  output logic                o_busy
);
  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t r_state;
  logic [3:0] r_op;
  logic r_req;
  logic [TW-1:0] r_tmr;
  logic [W-1:0] r_res, w_a, w_b;
  logic w_digit, w_op, w_eq, w_bs, w_clr, w_chain;
  assign w_digit = i_key_valid && i_key_code <= 4'd9;
  assign w_op    = i_key_valid && is_op(i_key_code);
  assign w_eq    = i_key_valid && i_key_code == KEY_EQ;
  assign w_bs    = i_key_valid && i_key_code == KEY_BS;
  assign w_clr   = i_key_valid && i_key_code == KEY_CLR;
`ifdef CALC_CHAIN_EN
  assign w_chain = w_op && r_state == SHOW;
`else
  assign w_chain = 1'b0;
`endif
  bcd_entry_reg #(.DIGITS(DIGITS)) u_a (
    .clk        (clk),
    .resetn     (resetn),
    .i_clr      (w_clr),
    .i_shift    (w_digit && r_state == ENTER_A),
    .i_back     (w_bs && r_state == ENTER_A),
    .i_load     ((w_digit && r_state == SHOW) || w_chain),
    .i_digit    (i_key_code),
    .i_load_val (w_chain ? r_res : W'(i_key_code)),
    .o_val      (w_a)
  );
  bcd_entry_reg #(.DIGITS(DIGITS)) u_b (
    .clk        (clk),
    .resetn     (resetn),
    .i_clr      (w_clr || (w_op && r_state == ENTER_A) || w_chain),
    .i_shift    (w_digit && r_state == ENTER_B),
    .i_back     (w_bs && r_state == ENTER_B),
    .i_load     (1'b0),
    .i_digit    (i_key_code),
    .i_load_val ('0),
    .o_val      (w_b)
  );
  always_ff @(posedge clk) begin
    if (!resetn || w_clr) begin
      r_state <= ENTER_A;
      r_op    <= OP_ADD;
      r_req   <= 1'b0;
      r_tmr   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        ENTER_A: if (w_op) begin
          r_op    <= key_to_op(i_key_code);
          r_state <= ENTER_B;
        end
        ENTER_B: if (w_op) r_op <= key_to_op(i_key_code);
        else if (w_eq) begin
          r_req   <= 1'b1;
          r_tmr   <= '0;
          r_state <= EXEC;
        end
        // an ack arriving on the timeout cycle still delivers its result
        EXEC: if (i_alu_ack) begin
          r_req   <= 1'b0;
          r_res   <= i_alu_res;
          r_state <= i_alu_err ? ERROR : SHOW;
        end else if (r_tmr == TW'(ACK_TIMEOUT - 1)) begin
          r_req   <= 1'b0;
          r_state <= ERROR;
        end else r_tmr <= r_tmr + 1'b1;
        SHOW: if (w_digit) r_state <= ENTER_A;
        else if (w_chain) begin
          r_op    <= key_to_op(i_key_code);
          r_state <= ENTER_B;
        end
        default: ;
      endcase
    end
  end
  assign o_display  = r_state == ENTER_A ? w_a :
                      (r_state == ENTER_B || r_state == EXEC) ? w_b :
                      r_state == SHOW ? r_res : '0;
  assign o_alu_num1 = w_a;
  assign o_alu_num2 = w_b;
  assign o_alu_op   = r_op;
  assign o_alu_req  = r_req;
  assign o_disp_err = r_state == ERROR;
  assign o_busy     = r_state == EXEC;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: randomized scoreboard bench for calc_sequencer with a decimal-level reference model.
module tb_calc_sequencer;
  localparam int D = 4, W = 16, AT = 8;
  localparam int MA = 0, MB = 1, MX = 2, MS = 3, ME = 4;
  logic clk = 0, resetn = 0, kv = 0, ack = 0, err = 0;
  logic [3:0] key = 0, op;
  logic [W-1:0] res = 0, num1, num2, disp;
  logic req, derr, busy;
  typedef struct {logic [W-1:0] disp, n1, n2; logic [3:0] op; logic err, busy;} exp_t;
  typedef struct {logic [W-1:0] n1, n2; logic [3:0] op;} txn_t;
  exp_t exp_q[$];
  txn_t txn_q[$];
  int dur_q[$];
  int checks = 0, errors = 0;
  int m_st, m_a, m_b;
  logic [3:0] m_op;
  logic [W-1:0] m_res;

  always #5 clk = ~clk;

  calc_sequencer #(.DIGITS(D), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .resetn(resetn), .i_key_valid(kv), .i_key_code(key),
    .o_alu_num1(num1), .o_alu_num2(num2), .o_alu_op(op), .o_alu_req(req),
    .i_alu_ack(ack), .i_alu_res(res), .i_alu_err(err),
    .o_display(disp), .o_disp_err(derr), .o_busy(busy)
  );

  function automatic logic [W-1:0] to_bcd(input int x);
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic int from_bcd(input logic [W-1:0] b);
    int x = 0;
    for (int i = D - 1; i >= 0; i--) x = x * 10 + int'(b[4*i+:4]);
    return x;
  endfunction
  function automatic int ndig(input int x);
    int n = 0;
    while (x > 0) begin
      x = x / 10;
      n++;
    end
    return n;
  endfunction
  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[4*i+:4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.disp = m_st == MA ? to_bcd(m_a) : (m_st == MB || m_st == MX) ? to_bcd(m_b) :
             m_st == MS ? m_res : '0;
    e.n1 = to_bcd(m_a);
    e.n2 = to_bcd(m_b);
    e.op = m_op;
    e.err = m_st == ME;
    e.busy = m_st == MX;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    m_st = MA; m_a = 0; m_b = 0; m_op = 0; m_res = '0;
  endtask

  // calculator semantics on plain decimal integers
  task automatic model_key(input logic [3:0] k);
    txn_t t;
    if (k == 4'hF) model_clear();
    else case (m_st)
      MA: if (k <= 9) begin
        if (ndig(m_a) < D) m_a = m_a * 10 + int'(k);
      end else if (k == 4'hE) m_a = m_a / 10;
      else if (k <= 4'hC) begin
        m_op = k - 4'hA; m_b = 0; m_st = MB;
      end
      MB: if (k <= 9) begin
        if (ndig(m_b) < D) m_b = m_b * 10 + int'(k);
      end else if (k == 4'hE) m_b = m_b / 10;
      else if (k <= 4'hC) m_op = k - 4'hA;
      else begin
        m_st = MX;
        t.n1 = to_bcd(m_a); t.n2 = to_bcd(m_b); t.op = m_op;
        txn_q.push_back(t);
      end
      MS: if (k <= 9) begin
        m_a = int'(k); m_st = MA;
      end else if (k <= 4'hC) begin
`ifdef CALC_CHAIN_EN
        m_a = from_bcd(m_res); m_op = k - 4'hA; m_b = 0; m_st = MB;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input logic k_v, input logic [3:0] k, input logic a,
                     input logic [W-1:0] r, input logic e, input logic rn);
    kv = k_v; key = k; ack = a; res = r; err = e; resetn = rn;
    @(posedge clk);
    #1 kv = 0; ack = 0; resetn = 1;
  endtask
  task automatic idle(); cyc(0, 4'h0, 0, '0, 0, 1); endtask
  task automatic press(input logic [3:0] k);
    model_key(k); push_exp(); cyc(1, k, 0, '0, 0, 1);
  endtask
  task automatic stray_ack();
    push_exp(); cyc(0, 4'h0, 1, rand_bcd(), 1'($urandom_range(0, 1)), 1);
  endtask
  task automatic do_reset();
    model_clear(); push_exp(); cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0, '0, 0, 0);
  endtask
  task automatic ack_after(input int n, input logic [W-1:0] rv, input logic e);
    dur_q.push_back(n + 1);
    repeat (n) idle();
    if (e) m_st = ME;
    else begin
      m_res = rv; m_st = MS;
    end
    push_exp(); cyc(0, 4'h0, 1, rv, e, 1);
  endtask
  task automatic time_out();
    dur_q.push_back(AT);
    repeat (AT) idle();
    m_st = ME;
    stray_ack();
  endtask

  task automatic alu_phase();
    int n = $urandom_range(0, AT - 1);
    int r = $urandom_range(0, 9);
    if (r == 9) time_out();
    else if (r < 6) begin
      dur_q.push_back(n + 1);
      for (int i = 0; i < n; i++)
        if ($urandom_range(0, 2) == 0) press(4'($urandom_range(0, 14))); else idle();
      if ($urandom_range(0, 5) == 0) m_st = ME;
      else begin
        m_res = rand_bcd(); m_st = MS;
      end
      push_exp(); cyc(0, 4'h0, 1, m_st == MS ? m_res : rand_bcd(), m_st == ME, 1);
    end else begin
      dur_q.push_back(n + 1);
      repeat (n) idle();
      if (r < 8) press(4'hF); else do_reset();
      stray_ack();
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT has been handed a key, ack or reset
  logic ev = 0;
  int hi = 0;
  always @(posedge clk) ev = kv || ack || !resetn;
  always @(negedge clk) begin
    exp_t e;
    txn_t t;
    if (ev) begin
      if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("display", 32'(disp), 32'(e.disp));
        chk("disp_err", 32'(derr), 32'(e.err));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("alu_req", 32'(req), 32'(e.busy));
        chk("alu_num1", 32'(num1), 32'(e.n1));
        chk("alu_num2", 32'(num2), 32'(e.n2));
        chk("alu_op", 32'(op), 32'(e.op));
      end
    end
    if (req) begin
      if (hi == 0) begin
        if (txn_q.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          t = txn_q.pop_front();
          chk("req_num1", 32'(num1), 32'(t.n1));
          chk("req_num2", 32'(num2), 32'(t.n2));
          chk("req_op", 32'(op), 32'(t.op));
        end
      end
      hi++;
    end else if (hi > 0) begin
      if (dur_q.size() == 0) chk("unexpected_req_fall", 1, 0);
      else chk("req_high_cycles", 32'(hi), 32'(dur_q.pop_front()));
      hi = 0;
    end
  end

  initial begin
    model_clear();
    do_reset();
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'hD);
    ack_after(2, 16'h0015, 0);
    press(4'hA); press(4'h2); press(4'hD);
    if (m_st == MX) ack_after(0, 16'h0017, 0);
    press(4'hF);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'hE);
    press(4'hF);
    press(4'h9); press(4'h9); press(4'hC); press(4'h9); press(4'h9); press(4'hD);
    ack_after(1, '0, 1);
    press(4'h5); press(4'hF);
    press(4'h1); press(4'hA); press(4'h1); press(4'hD);
    time_out();
    press(4'hF);
    press(4'h1); press(4'hB); press(4'h2); press(4'hD);
    dur_q.push_back(2);
    idle(); press(4'hF); stray_ack();
    press(4'h0); press(4'h0); press(4'h7); press(4'hE); press(4'hE); press(4'hE); press(4'h3);
    for (int it = 0; it < 400; it++) begin
      int r = $urandom_range(0, 99);
      if (m_st == ME && r < 50) press(4'hF);
      else if (r < 50) press(4'($urandom_range(0, 9)));
      else if (r < 62) press(4'($urandom_range(10, 12)));
      else if (r < 77) press(4'hD);
      else if (r < 89) press(4'hE);
      else if (r < 92) press(4'hF);
      else if (r < 96) stray_ack();
      else if (r < 98) do_reset();
      else idle();
      if (m_st == MX) alu_phase();
    end
    repeat (3) idle();
    chk("pending_events", 32'(exp_q.size()), 0);
    chk("pending_reqs", 32'(txn_q.size()), 0);
    chk("pending_req_falls", 32'(dur_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter DIGITS, default 4: BCD digits per operand; every operand, result and display bus SHALL be 4*DIGITS bits.
REQ-002 Parameter ACK_TIMEOUT, default 255: maximum clk cycles in EXEC without alu_ack before an error.
REQ-003 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-004 resetn  input  1  one clock; reset is synchronous and active-low.
REQ-005 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-006 key_code  input  4  0x0-0x9 digit, 0xA add, 0xB sub, 0xC mul, 0xD equals, 0xE backspace, 0xF clear.
REQ-007 alu_num1, alu_num2  output  4*DIGITS  BCD operands, stable while alu_req is high.
REQ-008 alu_op  output  4  0 add, 1 sub, 2 mul.
REQ-009 alu_req  output  1  request, held high until alu_ack, abort or timeout.
REQ-010 alu_ack  input  1  one-cycle strobe: result valid.
REQ-011 alu_res  input  4*DIGITS  BCD result, sampled only in the alu_ack cycle.
REQ-012 alu_err  input  1  overflow/invalid flag, sampled with alu_ack.
REQ-013 display  output  4*DIGITS  BCD value to be shown.
REQ-014 disp_err  output  1  error indication.
REQ-015 busy  output  1  high exactly while in EXEC.

Function
REQ-016 The FSM SHALL have the states ENTER_A, ENTER_B, EXEC, SHOW and ERROR; the display SHALL show operand A in ENTER_A, operand B in ENTER_B and EXEC, the result in SHOW, and 0 in ERROR.
REQ-017 An accepted digit SHALL shift left into the active operand (new digit in the LSD) and increment its digit count; at count==DIGITS the digit SHALL be ignored; a 0 at count 0 SHALL leave the count at 0.
REQ-018 Backspace SHALL shift the active operand right by one digit, with the count saturating at 0; in SHOW, ERROR and EXEC it SHALL be ignored.
REQ-019 An operator in ENTER_A SHALL latch alu_op, clear B and enter ENTER_B; an operator in ENTER_B SHALL replace the latched op and stay in ENTER_B.
REQ-020 Equals in ENTER_A SHALL be ignored; equals in ENTER_B SHALL raise alu_req on the next cycle and enter EXEC.
REQ-021 In EXEC all keys except clear SHALL be ignored.
REQ-022 alu_ack with alu_err=0 SHALL latch alu_res and enter SHOW; alu_ack with alu_err=1 SHALL enter ERROR; alu_req SHALL fall in the cycle after alu_ack.
REQ-023 The timeout counter SHALL reach ACK_TIMEOUT in EXEC -> alu_req low, ERROR; if alu_ack and timeout occur in the same cycle, alu_ack SHALL win.
REQ-024 alu_ack outside EXEC SHALL be ignored.
REQ-025 In SHOW, a digit SHALL start a new A holding that digit (ENTER_A); equals SHALL be ignored; operators SHALL follow REQ-035.
REQ-026 In ERROR disp_err SHALL be 1 and only clear SHALL be accepted.
REQ-027 Clear SHALL be accepted in every state, including EXEC, and return the block to the reset condition on the next cycle.
REQ-028 Latency: key_valid in cycle N SHALL update display/state at N+1; alu_ack in cycle M SHALL produce the result on display at M+1.

Reset
REQ-029 With resetn low at a clk edge: state ENTER_A; display, alu_num1, alu_num2, alu_op, digit counts and timeout counter 0; alu_req, busy and disp_err 0.
REQ-030 Reset during EXEC SHALL drop alu_req at that edge, and any following alu_ack SHALL be ignored.
REQ-031 key_valid SHALL be ignored while resetn is low.

Configuration
REQ-032 Macro CALC_CHAIN_EN SHALL select result chaining.
REQ-033 With CALC_CHAIN_EN defined, an operator in SHOW SHALL copy the result into A, latch the op and enter ENTER_B.
REQ-034 Without CALC_CHAIN_EN, an operator in SHOW SHALL be ignored.
REQ-035 Operators in SHOW SHALL behave per REQ-033/REQ-034.

Structure
REQ-036 Package calc_pkg SHALL hold the key-code constants, op-code constants and the FSM state enum.
REQ-037 Sub-module bcd_entry_reg (operand shift register with digit count, shift-in, backspace, clear and load) SHALL be instantiated twice, once for A and once for B.

Verification
REQ-038 Keys 1,2,+,3,= with alu_ack 3 cycles after alu_req and alu_res=0x0015 -> alu_num1=0x0012, alu_num2=0x0003, alu_op=0, alu_req high for 3 cycles, display=0x0015 one cycle after alu_ack.
REQ-039 Keys 1,2,3,4,5 -> display=0x1234; then E -> display=0x0123.
REQ-040 Keys 9,9,*,9,9,= with alu_ack and alu_err=1 -> disp_err=1, display=0; key 5 ignored; F -> ENTER_A, display=0, disp_err=0.
REQ-041 ACK_TIMEOUT=8, keys 1,+,1,= with no alu_ack -> alu_req low after 8 cycles, disp_err=1; a later alu_ack is ignored.
REQ-042 After result 0x0015, keys +,2,= -> with CALC_CHAIN_EN: alu_num1=0x0015, alu_num2=0x0002; without it: + ignored, display=0x0002 in ENTER_A.
REQ-043 F while alu_req is high -> alu_req low and busy low next cycle, display=0; the subsequent alu_ack leaves the state in ENTER_A.
